// File: rtl/dual_ritc_trigger_decider_pkg.sv
// Shared encodings and defaults for the dual-RITC trigger decider.
// Mode and FSM state constants are plain localparams so checkers can bind to them.
package dual_ritc_trigger_decider_pkg;

  localparam int NCORRBITS_DEF    = 12;
  localparam int INDEXBITS_DEF    = 6;
  localparam int HOLDOFF_BITS_DEF = 8;
  localparam int SCALER_BITS_DEF  = 16;
  localparam int WIN_BITS         = 4;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_OR  = 2'b01;
  localparam logic [1:0] MODE_AND = 2'b10;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_HOLDOFF = 1'b1;

  // Mode 11 is treated exactly like MODE_OFF.
  function automatic logic mode_fires(input logic [1:0] mode,
                                      input logic       or_cond,
                                      input logic       and_cond);
    logic f;
    f = 1'b0;
    if (mode == MODE_OR)  f = or_cond;
    if (mode == MODE_AND) f = and_cond;
    return f;
  endfunction

endpackage

// File: rtl/dual_ritc_trigger_decider_if.sv
// Correlator-side inputs, configuration and trigger/scaler outputs of the decider.
// There is no handshake: inputs are sampled every sysclk, outputs are plain registers.
interface dual_ritc_trigger_decider_if
  import dual_ritc_trigger_decider_pkg::*;
#(
  parameter int NCORRBITS    = NCORRBITS_DEF,
  parameter int INDEXBITS    = INDEXBITS_DEF,
  parameter int HOLDOFF_BITS = HOLDOFF_BITS_DEF,
  parameter int SCALER_BITS  = SCALER_BITS_DEF
) ();

  logic [NCORRBITS-1:0]    r0_max_i;
  logic [INDEXBITS-1:0]    r0_max_corr_i;
  logic [NCORRBITS-1:0]    r1_max_i;
  logic [INDEXBITS-1:0]    r1_max_corr_i;
  logic [NCORRBITS-1:0]    r0_thresh_i;
  logic [NCORRBITS-1:0]    r1_thresh_i;
  logic [1:0]              mode_i;
  logic [HOLDOFF_BITS-1:0] holdoff_i;
  logic                    scaler_clr_i;

  logic                    trig_o;
  logic [NCORRBITS-1:0]    trig_max_o;
  logic [INDEXBITS-1:0]    trig_corr_o;
  logic [1:0]              trig_src_o;
  logic                    busy_o;
  logic [SCALER_BITS-1:0]  r0_scaler_o;
  logic [SCALER_BITS-1:0]  r1_scaler_o;

  modport master (
    output r0_max_i, r0_max_corr_i, r1_max_i, r1_max_corr_i,
    output r0_thresh_i, r1_thresh_i, mode_i, holdoff_i, scaler_clr_i,
    input  trig_o, trig_max_o, trig_corr_o, trig_src_o, busy_o,
    input  r0_scaler_o, r1_scaler_o
  );

  modport slave (
    input  r0_max_i, r0_max_corr_i, r1_max_i, r1_max_corr_i,
    input  r0_thresh_i, r1_thresh_i, mode_i, holdoff_i, scaler_clr_i,
    output trig_o, trig_max_o, trig_corr_o, trig_src_o, busy_o,
    output r0_scaler_o, r1_scaler_o
  );

endinterface

// File: rtl/dual_ritc_trigger_decider_ritc_sat_scaler.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module ritc_sat_scaler #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dual_ritc_trigger_decider.sv
// Two-stage trigger decider behind the dual-RITC correlator: threshold compare,
// OR / windowed-AND coincidence, holdoff FSM and per-RITC rate scalers.
module dual_ritc_trigger_decider
  import dual_ritc_trigger_decider_pkg::*;
#(
  parameter int NCORRBITS    = NCORRBITS_DEF,
  parameter int INDEXBITS    = INDEXBITS_DEF,
  parameter int HOLDOFF_BITS = HOLDOFF_BITS_DEF,
  parameter int WINDOW       = 4,
  parameter int SCALER_BITS  = SCALER_BITS_DEF
) (
  input logic                        sysclk_i,
  input logic                        rst_n_i,
  dual_ritc_trigger_decider_if.slave bus
);

  // Stage 1: registered inputs and threshold hits.
  logic [NCORRBITS-1:0] r0_max_q, r0_max_d;
  logic [INDEXBITS-1:0] r0_idx_q, r0_idx_d;
  logic [NCORRBITS-1:0] r1_max_q, r1_max_d;
  logic [INDEXBITS-1:0] r1_idx_q, r1_idx_d;
  logic                 hit0_q, hit0_d;
  logic                 hit1_q, hit1_d;

  // Stage 2: decision, held event info, coincidence windows and FSM.
  logic                    trig_q, trig_d;
  logic [NCORRBITS-1:0]    trig_max_q, trig_max_d;
  logic [INDEXBITS-1:0]    trig_corr_q, trig_corr_d;
  logic [1:0]              trig_src_q, trig_src_d;
  logic [WIN_BITS-1:0]     win0_q, win0_d;
  logic [WIN_BITS-1:0]     win1_q, win1_d;
  logic [0:0]              state_q, state_d;
  logic [HOLDOFF_BITS-1:0] hcnt_q, hcnt_d;

  logic recent0;
  logic recent1;
  logic or_cond;
  logic and_cond;
  logic fire;
  logic pick_r1;
  logic win_clear;

  always_comb begin
    r0_max_d = bus.r0_max_i;
    r0_idx_d = bus.r0_max_corr_i;
    r1_max_d = bus.r1_max_i;
    r1_idx_d = bus.r1_max_corr_i;
    hit0_d   = (bus.r0_max_i > bus.r0_thresh_i);
    hit1_d   = (bus.r1_max_i > bus.r1_thresh_i);
  end

  always_comb begin
    recent0  = hit0_q | (win0_q != '0);
    recent1  = hit1_q | (win1_q != '0);
    or_cond  = hit0_q | hit1_q;
    and_cond = (hit0_q & recent1) | (hit1_q & recent0);
    fire     = (state_q == ST_IDLE) && mode_fires(bus.mode_i, or_cond, and_cond);
    // R1 is reported only when it alone hits or strictly beats R0.
    pick_r1  = hit1_q & (~hit0_q | (r1_max_q > r0_max_q));
  end

  always_comb begin
    trig_d      = fire;
    trig_max_d  = trig_max_q;
    trig_corr_d = trig_corr_q;
    trig_src_d  = trig_src_q;
    if (fire) begin
      trig_max_d  = pick_r1 ? r1_max_q : r0_max_q;
      trig_corr_d = pick_r1 ? r1_idx_q : r0_idx_q;
      trig_src_d  = {hit1_q, hit0_q};
    end
  end

  // Windows only live in AND mode while IDLE; a trigger consumes them.
  always_comb begin
    win_clear = (bus.mode_i != MODE_AND) || (state_q != ST_IDLE) || fire;
    win0_d    = win0_q;
    win1_d    = win1_q;
    if (win_clear) begin
      win0_d = '0;
      win1_d = '0;
    end else begin
      if (hit0_q)             win0_d = WIN_BITS'(WINDOW);
      else if (win0_q != '0)  win0_d = win0_q - WIN_BITS'(1);
      if (hit1_q)             win1_d = WIN_BITS'(WINDOW);
      else if (win1_q != '0)  win1_d = win1_q - WIN_BITS'(1);
    end
  end

  // HOLDOFF is entered on the trigger edge, so busy_o rises with trig_o and
  // stays high for holdoff_i cycles; the next fire is judged in the first IDLE cycle.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fire && (bus.holdoff_i != '0)) begin
          state_d = ST_HOLDOFF;
          hcnt_d  = bus.holdoff_i;
        end
      end
      ST_HOLDOFF: begin
        if (hcnt_q == HOLDOFF_BITS'(1)) begin
          state_d = ST_IDLE;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q - HOLDOFF_BITS'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        hcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r0_max_q    <= '0;
      r0_idx_q    <= '0;
      r1_max_q    <= '0;
      r1_idx_q    <= '0;
      hit0_q      <= 1'b0;
      hit1_q      <= 1'b0;
      trig_q      <= 1'b0;
      trig_max_q  <= '0;
      trig_corr_q <= '0;
      trig_src_q  <= '0;
      win0_q      <= '0;
      win1_q      <= '0;
      state_q     <= ST_IDLE;
      hcnt_q      <= '0;
    end else begin
      r0_max_q    <= r0_max_d;
      r0_idx_q    <= r0_idx_d;
      r1_max_q    <= r1_max_d;
      r1_idx_q    <= r1_idx_d;
      hit0_q      <= hit0_d;
      hit1_q      <= hit1_d;
      trig_q      <= trig_d;
      trig_max_q  <= trig_max_d;
      trig_corr_q <= trig_corr_d;
      trig_src_q  <= trig_src_d;
      win0_q      <= win0_d;
      win1_q      <= win1_d;
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
    end
  end

  ritc_sat_scaler #(.W(SCALER_BITS)) u_r0_scaler (
    .clk_i   (sysclk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (bus.scaler_clr_i),
    .inc_i   (hit0_q),
    .count_o (bus.r0_scaler_o)
  );

  ritc_sat_scaler #(.W(SCALER_BITS)) u_r1_scaler (
    .clk_i   (sysclk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (bus.scaler_clr_i),
    .inc_i   (hit1_q),
    .count_o (bus.r1_scaler_o)
  );

  // busy_o is the FSM state bit itself (IDLE = 0, HOLDOFF = 1).
  assign bus.trig_o      = trig_q;
  assign bus.trig_max_o  = trig_max_q;
  assign bus.trig_corr_o = trig_corr_q;
  assign bus.trig_src_o  = trig_src_q;
  assign bus.busy_o      = (state_q == ST_HOLDOFF);

endmodule

// File: tb/tb_dual_ritc_trigger_decider.sv
// Self-checking bench for dual_ritc_trigger_decider: expected triggers are queued
// at drive time with their due cycle and matched against trig_o every cycle.
module tb_dual_ritc_trigger_decider;
  import dual_ritc_trigger_decider_pkg::*;

  localparam int NC = 12;
  localparam int IB = 6;
  localparam int HB = 8;
  localparam int SB = 16;
  localparam int EW = 32 + NC + IB + 2;

  logic sysclk_i;
  logic rst_n_i;

  dual_ritc_trigger_decider_if #(.NCORRBITS(NC), .INDEXBITS(IB),
                                 .HOLDOFF_BITS(HB), .SCALER_BITS(SB)) bus ();

  dual_ritc_trigger_decider #(.NCORRBITS(NC), .INDEXBITS(IB), .HOLDOFF_BITS(HB),
                              .WINDOW(4), .SCALER_BITS(SB)) dut (
    .sysclk_i (sysclk_i),
    .rst_n_i  (rst_n_i),
    .bus      (bus.slave)
  );

  // Clock / reset
  initial sysclk_i = 1'b0;
  always #5 sysclk_i = ~sysclk_i;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic [EW-1:0] exp_q[$];

  // Driver tasks
  task automatic drive(input logic [NC-1:0] m0, input logic [IB-1:0] i0,
                       input logic [NC-1:0] m1, input logic [IB-1:0] i1);
    bus.r0_max_i      = m0;
    bus.r0_max_corr_i = i0;
    bus.r1_max_i      = m1;
    bus.r1_max_corr_i = i1;
  endtask

  task automatic drive_idle();
    drive('0, '0, '0, '0);
  endtask

  task automatic push_exp(input logic [NC-1:0] m, input logic [IB-1:0] c,
                          input logic [1:0] s, input int lat);
    exp_q.push_back({32'(cyc + lat), m, c, s});
  endtask

  // One clock; outputs sampled 1 ns after the edge, scoreboard matched here.
  task automatic tick();
    logic [EW-1:0] e;
    @(posedge sysclk_i);
    #1;
    cyc++;
    while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
      e = exp_q.pop_front();
      total++;
      $display("FAIL sb_missed_trig: trig_o never 1 at cycle %0d, required 1 (max=%0d)",
               int'(e[EW-1 -: 32]), e[NC+IB+1 -: NC]);
    end
    if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
      e = exp_q.pop_front();
      total++;
      if (bus.trig_o !== 1'b1 || bus.trig_max_o !== e[NC+IB+1 -: NC] ||
          bus.trig_corr_o !== e[IB+1 -: IB] || bus.trig_src_o !== e[1:0]) begin
        $display("FAIL sb_trig cyc %0d: got trig=%b max=%0d corr=%0d src=%b, required trig=1 max=%0d corr=%0d src=%b",
                 cyc, bus.trig_o, bus.trig_max_o, bus.trig_corr_o, bus.trig_src_o,
                 e[NC+IB+1 -: NC], e[IB+1 -: IB], e[1:0]);
      end else begin
        passed++;
      end
    end else if (bus.trig_o !== 1'b0) begin
      total++;
      $display("FAIL sb_spurious_trig cyc %0d: trig_o=%b, required 0", cyc, bus.trig_o);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_drain: %0d expected triggers left, required 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      passed++;
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    drive_idle();
    bus.r0_thresh_i  = 12'd100;
    bus.r1_thresh_i  = 12'd100;
    bus.mode_i       = MODE_OFF;
    bus.holdoff_i    = '0;
    bus.scaler_clr_i = 1'b0;
    ticks(3);
    total += 7;
    if (bus.trig_o !== 1'b0) $display("FAIL rst_trig: got %b, required 0", bus.trig_o); else passed++;
    if (bus.trig_max_o !== '0) $display("FAIL rst_max: got %0d, required 0", bus.trig_max_o); else passed++;
    if (bus.trig_corr_o !== '0) $display("FAIL rst_corr: got %0d, required 0", bus.trig_corr_o); else passed++;
    if (bus.trig_src_o !== '0) $display("FAIL rst_src: got %b, required 00", bus.trig_src_o); else passed++;
    if (bus.busy_o !== 1'b0) $display("FAIL rst_busy: got %b, required 0", bus.busy_o); else passed++;
    if (bus.r0_scaler_o !== '0) $display("FAIL rst_sc0: got %0d, required 0", bus.r0_scaler_o); else passed++;
    if (bus.r1_scaler_o !== '0) $display("FAIL rst_sc1: got %0d, required 0", bus.r1_scaler_o); else passed++;
    @(negedge sysclk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_or_single();
    bus.mode_i    = MODE_OR;
    bus.holdoff_i = '0;
    drive(12'd101, 6'd5, 12'd0, 6'd0);
    push_exp(12'd101, 6'd5, 2'b01, 2);
    tick();
    drive_idle();
    ticks(5);
    total += 2;
    if (bus.trig_max_o !== 12'd101) $display("FAIL or_held_max: got %0d, required 101", bus.trig_max_o); else passed++;
    if (bus.trig_corr_o !== 6'd5) $display("FAIL or_held_corr: got %0d, required 5", bus.trig_corr_o); else passed++;
    drive(12'd100, 6'd7, 12'd100, 6'd8);
    tick();
    drive_idle();
    ticks(5);
    check_drained("or_single");
  endtask

  task automatic test_or_both();
    bus.mode_i = MODE_OR;
    drive(12'd200, 6'd3, 12'd300, 6'd9);
    push_exp(12'd300, 6'd9, 2'b11, 2);
    tick();
    drive(12'd250, 6'd7, 12'd250, 6'd11);
    push_exp(12'd250, 6'd7, 2'b11, 2);
    tick();
    drive(12'd50, 6'd1, 12'd150, 6'd20);
    push_exp(12'd150, 6'd20, 2'b10, 2);
    tick();
    drive_idle();
    ticks(5);
    check_drained("or_both");
  endtask

  task automatic test_and_window();
    bus.mode_i = MODE_AND;
    drive_idle();
    ticks(3);
    // R0 at t, R1 at t+4: inside the window
    drive(12'd150, 6'd1, 12'd0, 6'd0);
    tick();
    drive_idle();
    ticks(3);
    drive(12'd0, 6'd0, 12'd160, 6'd2);
    push_exp(12'd160, 6'd2, 2'b10, 2);
    tick();
    drive_idle();
    ticks(8);
    // R0 at t, R1 at t+5: window expired
    drive(12'd150, 6'd1, 12'd0, 6'd0);
    tick();
    drive_idle();
    ticks(4);
    drive(12'd0, 6'd0, 12'd160, 6'd2);
    tick();
    drive_idle();
    ticks(8);
    // Lone hits
    drive(12'd400, 6'd9, 12'd0, 6'd0);
    tick();
    drive_idle();
    ticks(8);
    drive(12'd0, 6'd0, 12'd400, 6'd9);
    tick();
    drive_idle();
    ticks(8);
    // R1 first, R0 two cycles later: R0 event reported
    drive(12'd0, 6'd0, 12'd170, 6'd30);
    tick();
    drive_idle();
    tick();
    drive(12'd180, 6'd31, 12'd0, 6'd0);
    push_exp(12'd180, 6'd31, 2'b01, 2);
    tick();
    drive_idle();
    ticks(8);
    check_drained("and_window");
  endtask

  task automatic test_holdoff();
    int busy_cnt;
    int busy_rise;
    logic prev_busy;
    busy_cnt  = 0;
    busy_rise = 0;
    prev_busy = 1'b0;
    bus.mode_i    = MODE_OR;
    bus.holdoff_i = 8'd10;
    drive(12'd500, 6'd4, 12'd0, 6'd0);
    for (int k = 0; k < 4; k++) push_exp(12'd500, 6'd4, 2'b01, 2 + 11 * k);
    for (int i = 0; i < 50; i++) begin
      if (i == 35) drive_idle();
      tick();
      if (bus.busy_o === 1'b1) busy_cnt++;
      if (bus.busy_o === 1'b1 && prev_busy === 1'b0) busy_rise++;
      prev_busy = bus.busy_o;
    end
    total += 2;
    if (busy_cnt != 40) $display("FAIL holdoff_busy_cycles: got %0d, required 40", busy_cnt); else passed++;
    if (busy_rise != 4) $display("FAIL holdoff_busy_runs: got %0d, required 4", busy_rise); else passed++;
    check_drained("holdoff10");
    bus.holdoff_i = 8'd0;
    drive(12'd500, 6'd4, 12'd0, 6'd0);
    for (int k = 0; k < 8; k++) push_exp(12'd500, 6'd4, 2'b01, 2 + k);
    ticks(8);
    drive_idle();
    ticks(4);
    total++;
    if (bus.busy_o !== 1'b0) $display("FAIL holdoff0_busy: got %b, required 0", bus.busy_o); else passed++;
    check_drained("holdoff0");
  endtask

  task automatic test_scalers();
    int trig_seen;
    trig_seen = 0;
    bus.mode_i = MODE_OFF;
    drive_idle();
    ticks(3);
    bus.scaler_clr_i = 1'b1;
    tick();
    bus.scaler_clr_i = 1'b0;
    total += 2;
    if (bus.r0_scaler_o !== '0) $display("FAIL sc_clr0: got %0d, required 0", bus.r0_scaler_o); else passed++;
    if (bus.r1_scaler_o !== '0) $display("FAIL sc_clr1: got %0d, required 0", bus.r1_scaler_o); else passed++;
    drive(12'd500, 6'd1, 12'd500, 6'd2);
    for (int i = 0; i < 70000; i++) begin
      if (i == 5) drive(12'd500, 6'd1, 12'd0, 6'd0);
      tick();
      if (bus.trig_o === 1'b1) trig_seen++;
    end
    drive_idle();
    ticks(2);
    total += 3;
    if (bus.r0_scaler_o !== 16'hFFFF) $display("FAIL sc_sat0: got %h, required ffff", bus.r0_scaler_o); else passed++;
    if (bus.r1_scaler_o !== 16'd5) $display("FAIL sc_count1: got %0d, required 5", bus.r1_scaler_o); else passed++;
    if (trig_seen != 0) $display("FAIL sc_mode_off_trig: got %0d triggers, required 0", trig_seen); else passed++;
    // Clear lands on an edge where the R0 stage-1 hit is high
    drive(12'd500, 6'd1, 12'd0, 6'd0);
    ticks(2);
    bus.scaler_clr_i = 1'b1;
    tick();
    bus.scaler_clr_i = 1'b0;
    total++;
    if (bus.r0_scaler_o !== '0) $display("FAIL sc_clr_wins: got %0d, required 0", bus.r0_scaler_o); else passed++;
    tick();
    total++;
    if (bus.r0_scaler_o !== 16'd1) $display("FAIL sc_after_clr: got %0d, required 1", bus.r0_scaler_o); else passed++;
    drive_idle();
    ticks(3);
    check_drained("scalers");
  endtask

  task automatic test_reset_mid_holdoff();
    bus.mode_i    = MODE_OR;
    bus.holdoff_i = 8'd20;
    drive(12'd333, 6'd8, 12'd0, 6'd0);
    push_exp(12'd333, 6'd8, 2'b01, 2);
    tick();
    drive_idle();
    ticks(6);
    total++;
    if (bus.busy_o !== 1'b1) $display("FAIL mid_busy_before: got %b, required 1", bus.busy_o); else passed++;
    #2;
    rst_n_i = 1'b0;
    #1;
    total += 6;
    if (bus.busy_o !== 1'b0) $display("FAIL mid_rst_busy: got %b, required 0", bus.busy_o); else passed++;
    if (bus.trig_max_o !== '0) $display("FAIL mid_rst_max: got %0d, required 0", bus.trig_max_o); else passed++;
    if (bus.trig_corr_o !== '0) $display("FAIL mid_rst_corr: got %0d, required 0", bus.trig_corr_o); else passed++;
    if (bus.trig_src_o !== '0) $display("FAIL mid_rst_src: got %b, required 00", bus.trig_src_o); else passed++;
    if (bus.r0_scaler_o !== '0) $display("FAIL mid_rst_sc0: got %0d, required 0", bus.r0_scaler_o); else passed++;
    if (bus.r1_scaler_o !== '0) $display("FAIL mid_rst_sc1: got %0d, required 0", bus.r1_scaler_o); else passed++;
    #3;
    rst_n_i = 1'b1;
    drive(12'd0, 6'd0, 12'd400, 6'd12);
    push_exp(12'd400, 6'd12, 2'b10, 2);
    tick();
    drive_idle();
    ticks(6);
    total++;
    if (bus.r1_scaler_o !== 16'd1) $display("FAIL mid_post_sc1: got %0d, required 1", bus.r1_scaler_o); else passed++;
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_or_single();
    test_or_both();
    test_and_window();
    test_holdoff();
    test_scalers();
    test_reset_mid_holdoff();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
